// File: rtl/ml_min_sched_if.sv
// Handshake and result bus of the time-multiplexed 4-PAM minimum-distance detector.
// The master drives the vector and out_ready; the slave (the detector) returns results.
interface ml_min_sched_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] xI1;
  logic [N-1:0] xQ1;
  logic [N-1:0] xI2;
  logic [N-1:0] xQ2;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] min_dI1;
  logic [N-1:0] min_dQ1;
  logic [N-1:0] min_dI2;
  logic [N-1:0] min_dQ2;
  logic [2:0]   min_idx_dI1;
  logic [2:0]   min_idx_dQ1;
  logic [2:0]   min_idx_dI2;
  logic [2:0]   min_idx_dQ2;
  logic         busy;

  modport master (
    output in_valid, xI1, xQ1, xI2, xQ2, out_ready,
    input  in_ready, out_valid, busy,
    input  min_dI1, min_dQ1, min_dI2, min_dQ2,
    input  min_idx_dI1, min_idx_dQ1, min_idx_dI2, min_idx_dQ2
  );

  modport slave (
    input  in_valid, xI1, xQ1, xI2, xQ2, out_ready,
    output in_ready, out_valid, busy,
    output min_dI1, min_dQ1, min_dI2, min_dQ2,
    output min_idx_dI1, min_idx_dQ1, min_idx_dI2, min_idx_dQ2
  );
endinterface

// File: rtl/ml_min_sched.sv
// Minimum squared distance search over the fixed 4-PAM candidate set, sharing one
// subtract/square/compare unit across all 16 (component, candidate) pairs.
module ml_min_sched #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  ml_min_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [N-1:0] V0 = N'(-3 * (1 << Q));
  localparam logic signed [N-1:0] V1 = N'(-1 * (1 << Q));
  localparam logic signed [N-1:0] V2 = N'( 1 * (1 << Q));
  localparam logic signed [N-1:0] V3 = N'( 3 * (1 << Q));

  localparam logic [2*N+1:0] D_MAX = {{(N+3){1'b0}}, {(N-1){1'b1}}};
  localparam logic [N-1:0]   D_SAT = {1'b0, {(N-1){1'b1}}};

  state_t             state;
  logic [1:0]         comp;
  logic [1:0]         cand;
  logic [3:0][N-1:0]  x_lat;
  logic [N-1:0]       run_min;
  logic [1:0]         run_idx;
  logic [3:0][N-1:0]  min_d_r;
  logic [3:0][1:0]    min_idx_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;

  logic signed [N-1:0]   x_sel;
  logic signed [N-1:0]   v_sel;
  logic signed [N:0]     diff;
  logic signed [2*N+1:0] diff_ext;
  logic [2*N+1:0]        sq;
  logic [2*N+1:0]        d_full;
  logic [N-1:0]          d_sat;
  logic                  take;
  logic [N-1:0]          best_d;
  logic [1:0]            best_idx;

  // Shared datapath: one candidate distance per cycle, sign-extended so nothing wraps.
  assign x_sel    = $signed(x_lat[comp]);
  assign diff     = {x_sel[N-1], x_sel} - {v_sel[N-1], v_sel};
  assign diff_ext = {{(N+1){diff[N]}}, diff};
  assign sq       = diff_ext * diff_ext;
  assign d_full   = sq >> Q;
  assign d_sat    = (d_full > D_MAX) ? D_SAT : d_full[N-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    v_sel = V0;
    case (cand)
      2'd0:    v_sel = V0;
      2'd1:    v_sel = V1;
      2'd2:    v_sel = V2;
      default: v_sel = V3;
    endcase
  end

  // Strict less-than keeps the lower index on ties; cand 0 always seeds the search.
  always_comb begin
    take     = (cand == 2'd0) || (d_sat < run_min);
    best_d   = run_min;
    best_idx = run_idx;
    if (take) begin
      best_d   = d_sat;
      best_idx = cand;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the latched vector and result registers are reset too, because their
  // post-reset contents are observable on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      comp        <= 2'd0;
      cand        <= 2'd0;
      x_lat       <= '0;
      run_min     <= '0;
      run_idx     <= 2'd0;
      min_d_r     <= '0;
      min_idx_r   <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_lat      <= {bus.xQ2, bus.xI2, bus.xQ1, bus.xI1};
            comp       <= 2'd0;
            cand       <= 2'd0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= CALC;
          end
        end

        CALC: begin
          run_min <= best_d;
          run_idx <= best_idx;
          cand    <= cand + 2'd1;
          if (cand == 2'd3) begin
            min_d_r[comp]   <= best_d;
            min_idx_r[comp] <= best_idx;
            comp            <= comp + 2'd1;
            if (comp == 2'd3) begin
              busy_r      <= 1'b0;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.busy        = busy_r;
  assign bus.min_dI1     = min_d_r[0];
  assign bus.min_dQ1     = min_d_r[1];
  assign bus.min_dI2     = min_d_r[2];
  assign bus.min_dQ2     = min_d_r[3];
  assign bus.min_idx_dI1 = {1'b0, min_idx_r[0]};
  assign bus.min_idx_dQ1 = {1'b0, min_idx_r[1]};
  assign bus.min_idx_dI2 = {1'b0, min_idx_r[2]};
  assign bus.min_idx_dQ2 = {1'b0, min_idx_r[3]};

endmodule

// File: doc/ml_min_sched.md
# ml_min_sched

Time-multiplexed minimum-distance detector controller for the 4-PAM per-component slicer stage. It accepts one received vector (xI1, xQ1, xI2, xQ2, signed Q8.8) through a valid/ready handshake. It then sequences a single shared subtract/square/compare unit over all 16 (component, candidate) pairs and returns the four minimum squared distances and their candidate indices through a second handshake. It replaces four parallel fully combinational min-search trees where area matters more than throughput.

## Interface
- N, 16, data word width (signed, two's complement)
- Q, 8, fractional bits of all data words
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector present
- in_ready  out  1  block can accept a vector (IDLE only)
- xI1, xQ1, xI2, xQ2  in  N each  received components, Q8.8
- out_valid  out  1  result registers hold a new result
- out_ready  in  1  downstream accepts result
- min_dI1, min_dQ1, min_dI2, min_dQ2  out  N each  minimum squared distance, Q8.8, saturated
- min_idx_dI1, min_idx_dQ1, min_idx_dI2, min_idx_dQ2  out  3 each  winning candidate index 0..3
- busy  out  1  high in CALC

## Operation
- Candidate table, fixed: V0=0xFD00 (-3), V1=0xFF00 (-1), V2=0x0100 (+1), V3=0x0300 (+3).
- Component order: comp 0=xI1, 1=xQ1, 2=xI2, 3=xQ2. Candidate order 0..3 inside each component.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid, latch all four inputs, set comp=0, cand=0, go to CALC.
  - CALC: one (comp, cand) pair per cycle. After comp=3, cand=3, go to DONE.
  - DONE: out_valid=1. Hold until out_ready=1, then go to IDLE.
- Distance arithmetic:
  - diff = x - V[cand], computed in N+1 bits with no wrap.
  - sq = diff*diff in 2N+2 bits.
  - d = sq >> Q.
  - If d > 2^(N-1)-1, d = 0x7FFF. d is never negative.
- Running min:
  - cand=0 loads (d, 0) unconditionally.
  - cand>0 replaces only if d < running min (strict). Ties keep the lower index.
- At cand=3 the final (min, idx) for comp is written to that component's output registers in the same cycle.
- Output registers change only on those writes. They hold their values through DONE, IDLE and the next CALC until overwritten.
- in_valid is ignored outside IDLE. No input is accepted in the cycle DONE exits.
- Latched inputs are used for the whole computation. Changes on the x* ports after acceptance have no effect.

## Timing
- Reset (asynchronous, any state, including mid-CALC): state=IDLE, comp=cand=0, in_ready=1, out_valid=0, busy=0, all min_d*=0, all min_idx*=0, latched inputs=0.
- Acceptance at rising edge k (in_valid & in_ready):
  - busy=1 during cycles k+1 .. k+16.
  - min_dI1/idx written at edge k+4, min_dQ1 at k+8, min_dI2 at k+12, min_dQ2 at k+16.
  - out_valid=1 after edge k+16.
- out_valid and in_ready are never high together. out_valid falls at the edge where out_ready is sampled high in DONE. in_ready rises at that same edge.
- Minimum period with out_ready tied high: 18 cycles per vector (accept, 16 CALC, 1 DONE).
- out_ready held low: DONE persists indefinitely with outputs stable.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Nominal: xI1=0x0080, xQ1=0xFE00, xI2=0x0300, xQ2=0x0000, out_ready=1.
  - min_dI1=0x0040, idx 2.
  - min_dQ1=0x0100, idx 0 (tie between V0 and V1, lower index wins).
  - min_dI2=0x0000, idx 3.
  - min_dQ2=0x0100, idx 1 (tie between V1 and V2).
  - out_valid exactly 16 cycles after acceptance.
- Saturation: xQ2=0x8000 (-128); all four distances exceed range. Expect min_dQ2=0x7FFF, idx 0.
- Backpressure: out_ready=0 for 10 cycles in DONE.
  - out_valid stays 1, in_ready stays 0, outputs stay stable.
  - in_valid pulses in that window are ignored.
  - Release out_ready: in_ready=1 on the next cycle.
- Input hold-off: toggle the x* ports and in_valid during CALC. Results match the values latched at acceptance; no second acceptance occurs.
- Reset mid-CALC: assert rst_n=0 at cycle k+7.
  - All outputs go to 0 immediately, state returns to IDLE.
  - After release, a fresh vector completes with correct results at +16 cycles.
- Back-to-back with out_ready=1: 3 random vectors checked against a golden model (round-toward-floor >>8, saturation at 0x7FFF, lowest-index tie rule). Acceptances are spaced exactly 18 cycles apart.
